// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory bridge: access size encodings, the
// bridge FSM state type and the latched transaction record.
package mem_bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_DONE = 2'b11
    } mem_bridge_state_e;

    typedef struct packed {
        logic        sel_data;
        logic        we;
        logic        sign;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

endpackage

// File: rtl/mem_bridge_lane_fmt.sv
// Byte-lane formatting: store lane replication with byte enables, and load
// lane extraction with sign/zero extension. Purely combinational.
module lane_fmt
    import mem_bridge_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        be        = 4'b1111;
        wdata     = wd;
        rdata_ext = rdata;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{wd[7:0]}};
                // sign = 1 selects zero-extension (func3[2] semantics)
                rdata_ext = sign ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{wd[15:0]}};
                rdata_ext = sign ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata     = wd;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// Merges the instruction and data ports onto one request/grant/response
// memory bus, with lane formatting, per-port acks and a bus timeout.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_ack,
    input  logic        data_read,
    input  logic        data_write,
    input  logic        data_sign,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        data_ack,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mem_bridge_state_e state_q, state_d;
    mem_txn_t          txn_q, txn_new;
    logic [CW-1:0]     cnt_q;
    logic              err_q, err_set;
    logic [31:0]       inst_data_q, data_rd_q;
    logic              inst_pend, data_pend, pick_data, active, expired;
    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wdata, fmt_rdata;

    assign inst_pend = inst_read;
    assign data_pend = data_read | data_write;
    assign pick_data = data_pend && (DATA_FIRST || !inst_pend);
    assign active    = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign expired   = (TIMEOUT != 0) && active && (cnt_q == LIMIT);

    always_comb begin
        txn_new          = '0;
        txn_new.sel_data = pick_data;
        txn_new.we       = pick_data & data_write;
        txn_new.sign     = pick_data & data_sign;
        txn_new.size     = pick_data ? data_size : SIZE_WORD;
        txn_new.addr     = pick_data ? data_addr : inst_addr;
        txn_new.wdata    = pick_data ? data_write_data : 32'h0;
    end

    // Bus handshake: an address phase is accepted on a cycle where mem_req and
    // mem_gnt are both high; the response (read data or write completion) is
    // the single cycle mem_rvalid is high while in DATA. A handshake landing on
    // the expiry cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: if (inst_pend || data_pend) state_d = ST_ADDR;
            ST_ADDR: begin
                if (mem_gnt) begin
                    state_d = ST_DATA;
                end else if (expired) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_DATA: begin
                if (mem_rvalid) begin
                    state_d = ST_DONE;
                end else if (expired) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            txn_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            inst_data_q <= 32'h0;
            data_rd_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
                err_q <= 1'b0;
                if (inst_pend || data_pend) txn_q <= txn_new;
            end else if (active) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (err_set) err_q <= 1'b1;
            if ((state_q == ST_DATA) && mem_rvalid && !txn_q.we) begin
                if (txn_q.sel_data) data_rd_q   <= fmt_rdata;
                else                inst_data_q <= fmt_rdata;
            end
        end
    end

    lane_fmt u_lane_fmt (
        .size      (txn_q.size),
        .sign      (txn_q.sign),
        .addr_lo   (txn_q.addr[1:0]),
        .wd        (txn_q.wdata),
        .rdata     (mem_rdata),
        .be        (fmt_be),
        .wdata     (fmt_wdata),
        .rdata_ext (fmt_rdata)
    );

    assign mem_req        = (state_q == ST_ADDR);
    assign mem_we         = mem_req & txn_q.we;
    assign mem_addr       = mem_req ? {txn_q.addr[31:2], 2'b00} : 32'h0;
    assign mem_be         = mem_req ? fmt_be : 4'b0000;
    assign mem_wdata      = mem_req ? fmt_wdata : 32'h0;
    assign inst_ack       = (state_q == ST_DONE) && !txn_q.sel_data;
    assign data_ack       = (state_q == ST_DONE) && txn_q.sel_data;
    assign bus_err        = (state_q == ST_DONE) && err_q;
    assign inst_data      = inst_data_q;
    assign data_read_data = data_rd_q;

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the core's instruction and data memory interfaces.
- Merges both interfaces onto one word-wide request/grant/response memory bus with byte enables.
- Performs write-lane replication and read-lane extraction with sign/zero extension.
- Returns per-port completion pulses that the control unit uses to leave its fetch and memory states. It also enforces a bus timeout.

Parameters:
TIMEOUT, 255, cycles spent in ADDR+DATA before a transaction is aborted with an error; 0 disables the timeout
DATA_FIRST, 1, 1 = data port wins simultaneous requests; 0 = instruction port wins

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
inst_read  in  1  level fetch request, held until inst_ack
inst_addr  in  32  fetch address (word aligned)
inst_data  out  32  fetched word, registered, held until the next fetch completes
inst_ack  out  1  one-cycle completion pulse for fetch
data_read  in  1  level load request
data_write  in  1  level store request; read and write are never both high
data_sign  in  1  func3[2] semantics: 1 = zero-extend, 0 = sign-extend
data_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
data_addr  in  32  byte address (alignment already checked upstream)
data_write_data  in  32  store data, right-justified
data_read_data  out  32  extended load result, registered, held until the next load completes
data_ack  out  1  one-cycle completion pulse for load/store
bus_err  out  1  pulses with the ack when the transaction timed out
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  32  {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  address phase accepted when high together with mem_req
mem_rvalid  in  1  response phase; also serves as the write completion
mem_rdata  in  32  read word

Behaviour:
- Reset: all outputs 0, including inst_data and data_read_data. FSM goes to IDLE and the timeout counter is cleared.
- Reset asserted mid-transaction aborts at the next edge. No ack is issued, and a late mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: if any request is high, latch the port select, address, size, sign, we and wdata, then go to ADDR.
  - Arbitration on a simultaneous request follows DATA_FIRST. The losing request stays pending and is served next.
  - ADDR: drive mem_req=1 with the latched fields. Go to DATA on mem_gnt.
  - DATA: mem_req=0; wait for mem_rvalid. On mem_rvalid, capture the formatted read into the selected port's output register (loads and fetches only), then go to DONE. A store does not change data_read_data.
  - DONE: pulse the selected ack, plus bus_err if the transaction timed out. Go to IDLE.
- Core requests are not sampled in DONE. The core deasserts its request on the cycle after the ack, so it is not re-served.
- Minimum latency: request seen in IDLE at cycle 0, ack at cycle 3 (gnt at cycle 1, rvalid at cycle 2).
- mem_gnt and mem_rvalid are never accepted in the same cycle. A response needs the DATA state.
- Write formatting:
  - byte: be = 1<<addr[1:0], wdata = {4{wd[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}
  - word: be = 1111
- Fetches always use be = 1111 and we = 0.
- Read formatting: shift mem_rdata right by 8*addr[1:0], then extend bits [7:0] or [15:0] per size and data_sign. Word passes through unchanged.
- Timeout:
  - The counter increments each cycle in ADDR or DATA and clears in IDLE.
  - When it reaches TIMEOUT: go to DONE with the error flag set, leave the read registers unchanged, and drop mem_req.
- Latched request fields are stable from ADDR through DONE. Core inputs may change freely after the ack.

Decomposition:
- Size encodings (BYTE/HALF/WORD) are shared with the core and live in the existing defs package.
- The FSM state enum is added there as mem_bridge_state_e so verification can probe it.
- The formatting logic is a combinational sub-module, lane_fmt: inputs size, sign, addr[1:0], wd, rdata; outputs be, wdata, rdata_ext.

Test Plan:
- Fetch at 0x100, mem_gnt immediate, mem_rvalid next cycle with 0xDEADBEEF -> mem_addr=0x100, be=1111; inst_ack at cycle 3; inst_data=0xDEADBEEF.
- Load byte, sign-extend, addr 0x203, rdata 0x80AABBCC -> be=1000; data_read_data=0xFFFFFF80. The same load with data_sign=1 -> 0x00000080.
- Store half at addr 0x12, data 0x0000BEEF -> mem_addr=0x10, be=1100, wdata=0xBEEFBEEF, we=1; data_ack after mem_rvalid; data_read_data unchanged.
- inst_read and data_read asserted together with DATA_FIRST=1 -> data is served first, and the fetch begins after the data_ack cycle. Each ack fires exactly once.
- mem_gnt held low, TIMEOUT=4 -> mem_req drops after 4 cycles; data_ack and bus_err pulse together in the same cycle.
- rst asserted in DATA, then mem_rvalid arrives one cycle later -> no ack, outputs 0, FSM in IDLE.
